// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order writeback
// stage and long-latency units (mul/div). Writeback has priority; long-latency
// results wait in a small circular FIFO. A starvation counter occasionally
// stalls writeback for one cycle so that a buffered result can drain.
//
// Optional feature: define WB_FWD_EN to add the fwd_* lookup ports, which
// search the FIFO for the youngest pending write to a given register.

module wb_port_arbiter #(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_valid,
    input  logic [4:0]        pipe_dst,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [4:0]        mc_dst,
    input  logic [DATA_W-1:0] mc_data,
`ifdef WB_FWD_EN
    input  logic [4:0]        fwd_ra,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              rf_wen,
    output logic [4:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_LIMIT);

    // FIFO storage (data only, never reset) and control state
    logic [4:0]        dstMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starveCnt;

    // Per-cycle arbitration decisions
    logic grantPipe;
    logic grantFifo;
    logic stallPipe;
    logic enqueue;
    logic fifoEmpty;
    logic starved;

    logic [4:0]        headDst;
    logic [DATA_W-1:0] headData;

    assign fifoEmpty = (count == '0);
    assign starved   = (starveCnt == STV_LIMIT);
    assign headDst   = dstMem[head];
    assign headData  = dataMem[head];

    // A full FIFO refuses new results even when it is draining this cycle,
    // so a freed slot only becomes visible upstream on the following cycle.
    assign mc_ready   = !reset && (count != FULL_CNT);
    assign enqueue    = mc_valid && mc_ready;
    assign pipe_stall = stallPipe;

    // Grant selection: writeback first, FIFO head when writeback is idle or
    // has starved the FIFO for STARVE_LIMIT consecutive grants.
    always_comb begin
        grantPipe = 1'b0;
        grantFifo = 1'b0;
        stallPipe = 1'b0;
        if (!reset) begin
            if (fifoEmpty) begin
                grantPipe = pipe_valid;
            end else if (!pipe_valid || starved) begin
                grantFifo = 1'b1;
                stallPipe = pipe_valid;
            end else begin
                grantPipe = 1'b1;
            end
        end
    end

    // FIFO slot writes; an entry written now is only visible at head next cycle
    always_ff @(posedge clk) begin
        if (enqueue) begin
            dstMem[tail]  <= mc_dst;
            dataMem[tail] <= mc_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enqueue) begin
                tail <= tail + 1'b1;
            end
            if (grantFifo) begin
                head <= head + 1'b1;
            end
            case ({enqueue, grantFifo})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: counts writeback grants made while results are waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (grantFifo || fifoEmpty) begin
            starveCnt <= '0;
        end else if (grantPipe && !starved) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    // Registered write port; x0 writes are consumed but never enabled,
    // and address/data hold their last value when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wen <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
        end else if (grantPipe) begin
            rf_wen <= (pipe_dst != 5'd0);
            rf_wa  <= pipe_dst;
            rf_wd  <= pipe_data;
        end else if (grantFifo) begin
            rf_wen <= (headDst != 5'd0);
            rf_wa  <= headDst;
            rf_wd  <= headData;
        end else begin
            rf_wen <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    logic              fwdHit;
    logic [DATA_W-1:0] fwdData;
    logic [PTR_W-1:0]  scanIdx;

    // Forwarding lookup: scan oldest to youngest so the youngest match wins.
    // The head entry counts even in the cycle it is being dequeued.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        scanIdx = head;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (fwd_ra != 5'd0) && (dstMem[scanIdx] == fwd_ra)) begin
                fwdHit  = 1'b1;
                fwdData = dataMem[scanIdx];
            end
        end
    end

    assign fwd_hit  = fwdHit;
    assign fwd_data = fwdData;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Randomized and directed stimulus for wb_port_arbiter against a queue-based
// reference model. Expected register-file writes go into a scoreboard queue
// that a separate monitor drains one entry per clock edge.

module tb_wb_port_arbiter;

    localparam int DATA_W       = 64;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 4;

    logic              clk;
    logic              reset;
    logic              pipe_valid;
    logic [4:0]        pipe_dst;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_stall;
    logic              mc_valid;
    logic              mc_ready;
    logic [4:0]        mc_dst;
    logic [DATA_W-1:0] mc_data;
    logic [4:0]        fwd_ra;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              rf_wen;
    logic [4:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;

    wb_port_arbiter #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_valid(pipe_valid),
        .pipe_dst  (pipe_dst),
        .pipe_data (pipe_data),
        .pipe_stall(pipe_stall),
        .mc_valid  (mc_valid),
        .mc_ready  (mc_ready),
        .mc_dst    (mc_dst),
        .mc_data   (mc_data),
`ifdef WB_FWD_EN
        .fwd_ra    (fwd_ra),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
`endif
        .rf_wen    (rf_wen),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        dst;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        logic              wen;
        logic [4:0]        wa;
        logic [DATA_W-1:0] wd;
    } wr_t;

    // Reference model state
    ent_t mq[$];
    wr_t  expQ[$];
    int   starve;
    logic [4:0]        lastWa;
    logic [DATA_W-1:0] lastWd;
    logic lastStall;
    logic lastAccepted;

    int total;
    int bad;

    function automatic void chk(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // One clock of stimulus plus the model's view of that cycle
    task automatic step(input logic r, input logic pv, input logic [4:0] pd,
                        input logic [DATA_W-1:0] pdt, input logic mv,
                        input logic [4:0] md, input logic [DATA_W-1:0] mdt,
                        input logic [4:0] fra);
        logic expReady;
        logic expStall;
        logic gPipe;
        logic gFifo;
        logic expHit;
        logic [DATA_W-1:0] expFwd;
        ent_t h;
        ent_t n;
        wr_t  w;
        @(negedge clk);
        reset      = r;
        pipe_valid = pv;
        pipe_dst   = pd;
        pipe_data  = pdt;
        mc_valid   = mv;
        mc_dst     = md;
        mc_data    = mdt;
        fwd_ra     = fra;
        #1;
        gPipe = 1'b0;
        gFifo = 1'b0;
        expStall = 1'b0;
        if (r) begin
            expReady = 1'b0;
            mq.delete();
            starve = 0;
            lastWa = '0;
            lastWd = '0;
            w.wen = 1'b0;
            w.wa  = '0;
            w.wd  = '0;
        end else begin
            expReady = (mq.size() != DEPTH);
            expHit = 1'b0;
            expFwd = '0;
            foreach (mq[i]) begin
                if (fra != 5'd0 && mq[i].dst == fra) begin
                    expHit = 1'b1;
                    expFwd = mq[i].data;
                end
            end
`ifdef WB_FWD_EN
            chk("fwd_hit", 64'(fwd_hit), 64'(expHit));
            if (expHit) chk("fwd_data", fwd_data, expFwd);
`endif
            if (mq.size() == 0) begin
                gPipe = pv;
            end else if (!pv || starve == STARVE_LIMIT) begin
                gFifo = 1'b1;
                expStall = pv;
            end else begin
                gPipe = 1'b1;
            end
            if (gFifo || mq.size() == 0) starve = 0;
            else if (gPipe && starve < STARVE_LIMIT) starve++;
            w.wen = 1'b0;
            w.wa  = lastWa;
            w.wd  = lastWd;
            if (gPipe) begin
                w.wen = (pd != 5'd0);
                w.wa  = pd;
                w.wd  = pdt;
            end else if (gFifo) begin
                h = mq.pop_front();
                w.wen = (h.dst != 5'd0);
                w.wa  = h.dst;
                w.wd  = h.data;
            end
            lastWa = w.wa;
            lastWd = w.wd;
            if (mv && expReady) begin
                n.dst  = md;
                n.data = mdt;
                mq.push_back(n);
            end
        end
        chk("mc_ready", 64'(mc_ready), 64'(expReady));
        chk("pipe_stall", 64'(pipe_stall), 64'(expStall));
        expQ.push_back(w);
        lastStall    = expStall;
        lastAccepted = mv && expReady;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
    endtask

    // Monitor: compares the registered write port after every rising edge
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("rf_wen", 64'(rf_wen), 64'(e.wen));
                chk("rf_wa", 64'(rf_wa), 64'(e.wa));
                chk("rf_wd", rf_wd, e.wd);
            end
        end
    end

    initial begin
        logic              pv;
        logic [4:0]        pd;
        logic [DATA_W-1:0] pdt;
        logic              mv;
        logic [4:0]        md;
        logic [DATA_W-1:0] mdt;
        int pProb;
        int mProb;
        total = 0;
        bad = 0;
        starve = 0;
        lastWa = '0;
        lastWd = '0;
        lastStall = 1'b0;
        lastAccepted = 1'b0;
        reset = 1'b1;
        pipe_valid = 1'b0;
        pipe_dst = '0;
        pipe_data = '0;
        mc_valid = 1'b0;
        mc_dst = '0;
        mc_data = '0;
        fwd_ra = '0;

        // Reset held two cycles with a result offered; nothing may enter
        step(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h99, 5'd0);
        step(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h99, 5'd0);
        idle(2);

        // Writeback only
        step(1'b0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, '0, 5'd0);
        idle(1);

        // Long-latency result with writeback idle
        step(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 64'hAA, 5'd0);
        idle(3);

        // Starvation: one buffered entry under continuous writeback
        step(1'b0, 1'b1, 5'd1, 64'h100, 1'b1, 5'd11, 64'hBEEF, 5'd0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 5'(2 + i), 64'(16'h200 + i), 1'b0, 5'd0, '0, 5'd0);
        idle(2);

        // Fill the FIFO under continuous writeback, then an x0 writeback
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 5'(20 + i), 64'(16'h300 + i), 1'b1, 5'(3 + i), 64'(16'h400 + i), 5'd3);
        step(1'b0, 1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, '0, 5'd0);
        idle(6);

        // Forwarding: two pending writes to the same register
        step(1'b0, 1'b1, 5'd12, 64'h1, 1'b1, 5'd3, 64'h10, 5'd3);
        step(1'b0, 1'b1, 5'd13, 64'h2, 1'b1, 5'd3, 64'h20, 5'd3);
        step(1'b0, 1'b1, 5'd14, 64'h3, 1'b0, 5'd0, '0, 5'd3);
        step(1'b0, 1'b1, 5'd15, 64'h4, 1'b0, 5'd0, '0, 5'd0);
        idle(4);

        // Randomized traffic in phases of differing pressure, with a reset midway
        pv = 1'b0; pd = '0; pdt = '0; mv = 1'b0; md = '0; mdt = '0;
        for (int ph = 0; ph < 6; ph++) begin
            pProb = (ph % 3 == 0) ? 90 : ((ph % 3 == 1) ? 50 : 20);
            mProb = (ph % 2 == 0) ? 70 : 30;
            for (int c = 0; c < 120; c++) begin
                if (!lastStall) begin
                    pv  = ($urandom_range(99) < pProb);
                    pd  = 5'($urandom_range(7));
                    pdt = {$urandom, $urandom};
                end
                if (!mv || lastAccepted) begin
                    mv  = ($urandom_range(99) < mProb);
                    md  = 5'($urandom_range(7));
                    mdt = {$urandom, $urandom};
                end
                if (ph == 3 && c == 60) begin
                    step(1'b1, pv, pd, pdt, mv, md, mdt, 5'($urandom_range(7)));
                    mv = 1'b0;
                    lastStall = 1'b0;
                end else begin
                    step(1'b0, pv, pd, pdt, mv, md, mdt, 5'($urandom_range(7)));
                end
            end
        end
        idle(8);

        // Scoreboard must drain within a bounded number of cycles
        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected writes left, required 0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
